cdb_broadcast_arbiter: RTL and testbench

Multi-producer common-data-bus (CDB) arbiter and broadcast register for the out-of-order core. It replaces the single-participant priority arbitration with N producer channels: the ALU execution unit, future execution units and the load path. It supports fixed-priority and round-robin modes, with an aging override that bounds how long any producer can wait. The winning producer's tag/data is registered and broadcast to all CDB consumers (reservation stations, register file controller) for exactly one cycle.

---
 rtl/cdb_broadcast_arbiter.sv | 116 +++++++++++
 tb/tb_cdb_broadcast_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/cdb_broadcast_arbiter.sv
// Common-data-bus arbiter: picks one of N producers (fixed/round-robin with aging override), registers its tag/data.
// Grant is combinational (0 cycles), broadcast follows 1 cycle later; a producer holds req until it sees its grant.
module cdb_broadcast_arbiter #(
  parameter int PARTICIPANTS  = 4,
  parameter int DATA_WIDTH    = 4,
  parameter int CDB_TAG_WIDTH = 4,
  parameter int MAX_WAIT      = 7
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  rr_mode,
  input  logic [PARTICIPANTS-1:0]               req,
  input  logic [PARTICIPANTS*CDB_TAG_WIDTH-1:0] req_tag,
  input  logic [PARTICIPANTS*DATA_WIDTH-1:0]    req_data,
  output logic [PARTICIPANTS-1:0]               grant,
  output logic                                  cdb_valid,
  output logic [CDB_TAG_WIDTH-1:0]              cdb_tag,
  output logic [DATA_WIDTH-1:0]                 cdb_data,
  output logic                                  aged_grant
);

  localparam int PW = $clog2(PARTICIPANTS);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_SAT = CW'(MAX_WAIT);
  localparam logic [PW-1:0] LAST_IDX = PW'(PARTICIPANTS - 1);

  typedef struct packed {
    logic                     vld;
    logic                     aged;
    logic [CDB_TAG_WIDTH-1:0] tag;
    logic [DATA_WIDTH-1:0]    dat;
  } cdb_t;

  logic [PW-1:0] rr_ptr;
  logic [CW-1:0] wait_cnt [PARTICIPANTS];
  logic [PW-1:0] aged_idx, fix_idx, rr_idx, winner;
  logic          aged_hit, fix_hit, rr_hit, any_req;
  cdb_t          cdb_d, cdb_q;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= PARTICIPANTS) s = s - PARTICIPANTS;
    return PW'(s);
  endfunction

  // Aged requesters and plain fixed priority both resolve to the lowest index.
  always_comb begin
    aged_hit = 1'b0;
    aged_idx = '0;
    fix_hit  = 1'b0;
    fix_idx  = '0;
    for (int i = 0; i < PARTICIPANTS; i++) begin
      if (!aged_hit && req[i] && wait_cnt[i] == WAIT_SAT) begin
        aged_hit = 1'b1;
        aged_idx = PW'(i);
      end
      if (!fix_hit && req[i]) begin
        fix_hit = 1'b1;
        fix_idx = PW'(i);
      end
    end
  end

  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int k = 0; k < PARTICIPANTS; k++) begin
      if (!rr_hit && req[wrap_add(rr_ptr, k)]) begin
        rr_hit = 1'b1;
        rr_idx = wrap_add(rr_ptr, k);
      end
    end
  end

  always_comb begin
    any_req = |req;
    if (aged_hit)     winner = aged_idx;
    else if (rr_mode) winner = rr_idx;
    else              winner = fix_idx;

    grant = '0;
    cdb_d = '0;
    for (int i = 0; i < PARTICIPANTS; i++) begin
      if (any_req && winner == PW'(i)) begin
        grant[i]  = 1'b1;
        cdb_d.vld  = 1'b1;
        cdb_d.aged = aged_hit;
        cdb_d.tag  = req_tag[i*CDB_TAG_WIDTH +: CDB_TAG_WIDTH];
        cdb_d.dat  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // rr_ptr only moves on a grant so an idle gap or mode switch resumes cleanly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      cdb_q  <= '0;
      for (int i = 0; i < PARTICIPANTS; i++) wait_cnt[i] <= '0;
    end else begin
      if (any_req) rr_ptr <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
      cdb_q <= cdb_d;
      for (int i = 0; i < PARTICIPANTS; i++) begin
        if (grant[i] || !req[i])       wait_cnt[i] <= '0;
        else if (wait_cnt[i] != WAIT_SAT) wait_cnt[i] <= wait_cnt[i] + 1'b1;
      end
    end
  end

  assign cdb_valid  = cdb_q.vld;
  assign aged_grant = cdb_q.aged;
  assign cdb_tag    = cdb_q.tag;
  assign cdb_data   = cdb_q.dat;

endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// Directed vectors with hand-computed grants; expected broadcasts are queued and checked by a separate monitor.
module tb_cdb_broadcast_arbiter;

  typedef struct packed {
    logic       rst_n;
    logic       mode;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       aged;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [3:0] tag;
    logic [3:0] dat;
    logic       aged;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rr_mode;
  logic [3:0]  req;
  logic [15:0] req_tag;
  logic [15:0] req_data;
  logic [3:0]  grant;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [3:0]  cdb_data;
  logic        aged_grant;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vq[$];
  exp_t sb[$];

  cdb_broadcast_arbiter #(
    .PARTICIPANTS(4), .DATA_WIDTH(4), .CDB_TAG_WIDTH(4), .MAX_WAIT(7)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rr_mode(rr_mode), .req(req),
    .req_tag(req_tag), .req_data(req_data), .grant(grant),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .aged_grant(aged_grant)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t v(input logic r, input logic m, input logic [3:0] rq,
                             input logic [3:0] g, input logic a);
    vec_t t;
    t.rst_n = r; t.mode = m; t.req = rq; t.gnt = g; t.aged = a;
    return t;
  endfunction

  // Channel i carries tag i and data 3*i+5.
  function automatic logic [3:0] ch_data(input int i);
    return 4'(i * 3 + 5);
  endfunction

  // Monitor: compares each registered broadcast against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (cyc >= 1) begin
      if (cdb_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 16'(cdb_valid), 16'h0);
        end else begin
          e = sb.pop_front();
          chk("bcast_cycle", 16'(cyc), 16'(e.cyc));
          chk("cdb_tag", 16'(cdb_tag), 16'(e.tag));
          chk("cdb_data", 16'(cdb_data), 16'(e.dat));
          chk("aged_grant", 16'(aged_grant), 16'(e.aged));
        end
      end else begin
        chk("idle_cdb", {cdb_valid, aged_grant, 6'd0, cdb_tag, cdb_data}, 16'h0);
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          chk("missed_bcast", 16'(cdb_valid), 16'h1);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    exp_t e;
    vec_t t;
    for (int i = 0; i < 4; i++) begin
      req_tag[i*4 +: 4]  = 4'(i);
      req_data[i*4 +: 4] = ch_data(i);
    end
    rst_n = 1'b0; rr_mode = 1'b1; req = 4'b1111;
    repeat (2) @(posedge clk);

    // reset held, then round robin 0,1,2,3,0
    vq.push_back(v(0, 1, 4'b1111, 4'b0001, 0));
    vq.push_back(v(1, 1, 4'b1111, 4'b0001, 0));
    vq.push_back(v(1, 1, 4'b1111, 4'b0010, 0));
    vq.push_back(v(1, 1, 4'b1111, 4'b0100, 0));
    vq.push_back(v(1, 1, 4'b1111, 4'b1000, 0));
    vq.push_back(v(1, 1, 4'b1111, 4'b0001, 0));
    // idle keeps rr_ptr, round robin resumes at channel 1
    repeat (3) vq.push_back(v(1, 1, 4'b0000, 4'b0000, 0));
    vq.push_back(v(1, 1, 4'b1111, 4'b0010, 0));
    // mode switch around a grant to channel 2
    vq.push_back(v(1, 1, 4'b0100, 4'b0100, 0));
    vq.push_back(v(1, 0, 4'b1100, 4'b0100, 0));
    vq.push_back(v(1, 1, 4'b1100, 4'b1000, 0));
    // fixed priority
    repeat (3) vq.push_back(v(1, 0, 4'b0110, 4'b0010, 0));
    vq.push_back(v(1, 0, 4'b0000, 4'b0000, 0));
    // aging: channel 1 wins on the 8th cycle
    repeat (7) vq.push_back(v(1, 0, 4'b0011, 4'b0001, 0));
    vq.push_back(v(1, 0, 4'b0011, 4'b0010, 1));
    vq.push_back(v(1, 0, 4'b0011, 4'b0001, 0));
    vq.push_back(v(1, 0, 4'b0000, 4'b0000, 0));
    // two simultaneously aged requesters: lowest first, other next cycle
    repeat (7) vq.push_back(v(1, 0, 4'b1110, 4'b0010, 0));
    vq.push_back(v(1, 0, 4'b1110, 4'b0100, 1));
    vq.push_back(v(1, 0, 4'b1110, 4'b1000, 1));
    vq.push_back(v(1, 0, 4'b1110, 4'b0010, 0));
    // reset mid-stream drops the grant and rr_ptr
    vq.push_back(v(1, 1, 4'b1111, 4'b0100, 0));
    vq.push_back(v(0, 1, 4'b1111, 4'b1000, 0));
    vq.push_back(v(1, 1, 4'b1111, 4'b0001, 0));
    vq.push_back(v(1, 1, 4'b0000, 4'b0000, 0));

    foreach (vq[k]) begin
      t = vq[k];
      @(negedge clk);
      rst_n = t.rst_n; rr_mode = t.mode; req = t.req;
      #1;
      chk($sformatf("grant[v%0d]", k), 16'(grant), 16'(t.gnt));
      if (t.rst_n && t.gnt != 4'b0000) begin
        for (int i = 0; i < 4; i++) begin
          if (t.gnt[i]) begin
            e.cyc = cyc + 1; e.tag = 4'(i); e.dat = ch_data(i); e.aged = t.aged;
            sb.push_back(e);
          end
        end
      end
    end

    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard_drained", 16'(sb.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
